// File: rtl/sha3_absorb_ctrl.sv
// rtl/sha3_absorb_ctrl.sv - SHA-3 absorb controller: beat packing, pad10*1, keccak core sequencing
// Optional feature macro: SHA3_ABSORB_STATS_EN (adds the blocks_absorbed counter port)
module sha3_absorb_ctrl #(
  parameter int D = 256,
  parameter int S = 1,
  parameter int W = 64,
  parameter logic [7:0] SUFFIX = 8'h06
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  input  logic                     in_last,
  input  logic [$clog2(W/8+1)-1:0] in_bytes,
  output logic                     core_reset,
  output logic                     core_enable,
  output logic [1600-2*D-1:0]      core_message,
  input  logic [D-1:0]             core_digest,
  output logic                     digest_valid,
  input  logic                     digest_ready,
  output logic [D-1:0]             digest
`ifdef SHA3_ABSORB_STATS_EN
  ,
  output logic [15:0]              blocks_absorbed
`endif
);

  localparam int R  = 1600 - 2 * D;
  localparam int RB = R / 8;
  localparam int BB = W / 8;
  localparam int NW = $clog2(RB + 1);
  localparam int BW = $clog2(W / 8 + 1);
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  // Block made only of padding, used when the message ends exactly on a block boundary.
  localparam logic [R-1:0] PAD_BLK = {SUFFIX, {(R - 16){1'b0}}, 8'h80};

  typedef enum logic [1:0] {IDLE, FILL, ABSORB, DONE} state_t;

  state_t         state, state_d;
  logic [R-1:0]   blk, blk_base, blk_fill;
  logic [NW-1:0]  n, n_base, n_after;
  logic [BW-1:0]  k;
  logic [CW-1:0]  cnt;
  logic           final_q, pad_pending, cap, live;
  logic           accept, block_end;

  assign accept       = in_valid && in_ready;
  assign block_end    = (cnt == CW'(S - 1));
  assign n_base       = (state == IDLE) ? '0 : n;
  assign blk_base     = (state == IDLE) ? '0 : blk;
  assign k            = in_last ? in_bytes : BW'(BB);
  assign n_after      = n_base + NW'(k);
  assign core_message = blk;

  // Merge the incoming beat into the block buffer and apply padding on the last beat.
  always_comb begin
    blk_fill = blk_base;
    for (int i = 0; i < RB; i++) begin
      for (int j = 0; j < BB; j++) begin
        if (i == int'(n_base) + j && j < int'(k))
          blk_fill[R-1-8*i -: 8] = in_data[W-1-8*j -: 8];
      end
      if (in_last && int'(n_after) == i)
        blk_fill[R-1-8*i -: 8] = SUFFIX;
    end
    if (in_last && n_after < NW'(RB))
      blk_fill[7:0] = blk_fill[7:0] | 8'h80;
  end

  // Next-state and control outputs.
  always_comb begin
    state_d     = state;
    in_ready    = 1'b0;
    core_reset  = 1'b0;
    core_enable = 1'b0;
    case (state)
      IDLE: begin
        core_reset = 1'b1;
        in_ready   = live;
        if (accept)
          state_d = (in_last || n_after == NW'(RB)) ? ABSORB : FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (accept && (in_last || n_after == NW'(RB)))
          state_d = ABSORB;
      end
      ABSORB: begin
        core_enable = 1'b1;
        if (block_end) begin
          if (final_q)          state_d = DONE;
          else if (pad_pending) state_d = ABSORB;
          else                  state_d = FILL;
        end
      end
      DONE: begin
        if (digest_valid && digest_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Block buffer, byte count, absorb counter and digest capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blk          <= '0;
      n            <= '0;
      cnt          <= '0;
      final_q      <= 1'b0;
      pad_pending  <= 1'b0;
      cap          <= 1'b0;
      live         <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE, FILL: begin
          if (accept) begin
            blk         <= blk_fill;
            n           <= n_after;
            cnt         <= '0;
            final_q     <= in_last && (n_after != NW'(RB));
            pad_pending <= in_last && (n_after == NW'(RB));
          end
        end
        ABSORB: begin
          cnt <= cnt + 1'b1;
          if (block_end) begin
            cnt <= '0;
            if (final_q) begin
              cap <= 1'b1;
            end else if (pad_pending) begin
              blk         <= PAD_BLK;
              pad_pending <= 1'b0;
              final_q     <= 1'b1;
            end else begin
              blk <= '0;
              n   <= '0;
            end
          end
        end
        DONE: begin
          if (cap) begin
            digest       <= core_digest;
            digest_valid <= 1'b1;
            cap          <= 1'b0;
          end else if (digest_valid && digest_ready) begin
            digest_valid <= 1'b0;
            blk          <= '0;
            n            <= '0;
            final_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA3_ABSORB_STATS_EN
  // Count finished block absorbs across messages, saturating at the top.
  always_ff @(posedge clk) begin
    if (!reset_n)
      blocks_absorbed <= '0;
    else if (state == ABSORB && block_end && blocks_absorbed != 16'hFFFF)
      blocks_absorbed <= blocks_absorbed + 16'd1;
  end
`endif

endmodule

// File: doc/sha3_absorb_ctrl.md
# sha3_absorb_ctrl

Streaming SHA-3 absorb controller that sits between a byte-oriented message source and the `keccak` core. Accepts a message as W-bit beats with valid/ready, assembles r-bit rate blocks, applies the pad10*1 rule with a configurable domain suffix, and sequences the core's reset and enable for S cycles per block. Returns the digest with a valid/ready handshake. This moves chunking and padding out of the bench and into hardware, generalised over digest length, beat width and SHA3/SHAKE suffix.

## Interface
- `D`, 256: digest length; 224, 256, 384 or 512. Rate is r = 1600 − 2·D.
- `S`, 1: keccak core stage count; any integer divisor of 24. Equals enabled cycles per block.
- `W`, 64: input beat width in bits; one of 8, 16, 32, 64. Divides r.
- `SUFFIX`, 8'h06: domain-separation byte. 8'h06 selects SHA-3; 8'h1F selects SHAKE.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_data` in W: beat data; first message byte occupies `in_data[W-1:W-8]`.
- `in_last` in 1: beat is the final beat of the message.
- `in_bytes` in $clog2(W/8+1): number of valid bytes, 0..W/8. Sampled only with `in_last`; non-last beats are always full.
- `core_reset` out 1: active-high reset to the core.
- `core_enable` out 1: core advances only while high.
- `core_message` out r: rate block; byte 0 in bits [r-1:r-8].
- `core_digest` in D: digest from the core.
- `digest_valid` out 1: digest available.
- `digest_ready` in 1: consumer accepts the digest.
- `digest` out D: registered digest.

## Operation
- States: IDLE, FILL, ABSORB, DONE.
- IDLE:
  - `core_reset`=1, `in_ready`=1, block buffer cleared, byte count n=0.
  - On an accepted beat, store it and go to FILL.
- FILL:
  - `core_reset`=0, `in_ready`=1.
  - Each accepted beat writes bytes n..n+k−1, then n += k.
  - A non-last beat that makes n = r/8 moves to ABSORB (final=0).
- Last beat, when n is less than r/8 after writing:
  - byte[n] = SUFFIX; bytes n+1..r/8−1 = 0; byte[r/8−1] |= 8'h80.
  - If n = r/8−1, the single pad byte is SUFFIX|8'h80 (8'h86 for SHA-3).
  - Go to ABSORB with final=1.
- Last beat that makes n = r/8 exactly:
  - Absorb the full block with final=0 and set pad_pending.
  - After that ABSORB, build an all-pad block (byte0=SUFFIX, bytes 1..r/8−2 = 0, last byte = 8'h80) without accepting input, then ABSORB with final=1.
- Empty message: `in_last` with `in_bytes`=0 in IDLE gives a single pad-only block.
- Bytes beyond `in_bytes` in the last beat are ignored.
- ABSORB:
  - `in_ready`=0, `core_enable`=1, `core_message` held stable for exactly S cycles.
  - On exit: if final, go to DONE; otherwise clear the buffer, set n=0 and go to FILL (or build the pad block if pad_pending).
- DONE:
  - Entry cycle captures `core_digest` into `digest`.
  - `digest_valid`=1 from the next cycle until `digest_ready` is sampled high, then go to IDLE.
  - `in_ready`=0 throughout DONE.

## Timing
- Reset values: `in_ready`=0, `core_reset`=1, `core_enable`=0, `core_message`=0, `digest_valid`=0, `digest`=0, state IDLE.
- `in_ready` rises on the first cycle after `reset_n` is seen high.
- Beat to ABSORB: the block-completing beat accepted at edge t gives `core_enable`=1 at cycles t+1..t+S.
- Digest latency: `digest_valid` rises 2 cycles after the last `core_enable` cycle.
- `digest` and `digest_valid` stay stable while `digest_ready`=0.
- Handshake at the DONE edge: `digest_valid`=0 and `core_reset`=1 on the next cycle. A new message may start 1 cycle later.
- `reset_n` low in any state returns to IDLE on the next edge; an in-flight message is discarded.
- `in_valid` with `in_ready`=0 is ignored. Data must be held by the source.

## Configuration
- `SHA3_ABSORB_STATS_EN` defined: adds output port `blocks_absorbed` [15:0].
  - Increments on each ABSORB exit and saturates at 16'hFFFF.
  - Cleared by reset only; not cleared between messages.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

## Test plan
- D=256, S=1, W=64, empty message (`in_last`, `in_bytes`=0) -> one block with byte0=06 and last byte=80; digest a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a.
- D=256, S=4, "abc" as one beat, `in_bytes`=3 -> `core_enable` high 4 cycles; digest 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
- D=256, 135 bytes -> one block, byte 134 = 86; `blocks_absorbed`=1.
- D=256, 136 bytes -> two absorbs; second block 06,00..00,80; `blocks_absorbed`=2.
- `digest_ready` held 0 for 10 cycles -> `digest_valid` and `digest` stable, `in_ready`=0; on release, IDLE with `core_reset`=1 the next cycle.
- `reset_n` pulsed low mid-ABSORB -> next cycle `core_enable`=0 and `core_reset`=1; then `in_ready`=1, and the following message hashes correctly.
